// File: rtl/gated_reg_bank.sv
// Multi-channel enable register bank for clock-gating analysis: per-channel straight/reversed
// capture of a shared bus, idle tracking with a gate request, and effective-load counting.
module gated_reg_bank #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS-1:0]       REV,
  input  logic                      CLR,
  input  logic [WIDTH-1:0]          D_IN,
  output logic [CHANNELS*WIDTH-1:0] OUT,
  output logic [CHANNELS-1:0]       GATE_OFF,
  output logic [CHANNELS-1:0]       UPD,
  output logic [CHANNELS*CNT_W-1:0] LOAD_CNT
);

  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] d_rev;

  always_comb begin
    d_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      d_rev[i] = D_IN[WIDTH-1-i];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] out_q, out_d, nv;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd_q, chg;

    assign nv  = REV[c] ? d_rev : D_IN;
    // A load only counts as useful when it actually changes the stored value.
    assign chg = EN[c] && (nv != out_q);

    always_comb begin
      out_d = EN[c] ? nv : out_q;

      idle_d = idle_q;
      if (CLR || EN[c]) begin
        idle_d = '0;
      end else if (idle_q != IdleMax) begin
        idle_d = idle_q + 1'b1;
      end

      cnt_d = cnt_q;
      if (CLR) begin
        cnt_d = '0;
      end else if (chg && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        out_q  <= '0;
        idle_q <= '0;
        cnt_q  <= '0;
        upd_q  <= 1'b0;
      end else begin
        out_q  <= out_d;
        idle_q <= idle_d;
        cnt_q  <= cnt_d;
        upd_q  <= chg;
      end
    end

    assign OUT[c*WIDTH +: WIDTH]      = out_q;
    assign LOAD_CNT[c*CNT_W +: CNT_W] = cnt_q;
    assign GATE_OFF[c]                = (idle_q == IdleMax);
    assign UPD[c]                     = upd_q;
  end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Directed checks on a 2x5-bit bank with a 3-bit counter, plus a randomised scoreboard run on a
// 4x8-bit bank.
module tb_gated_reg_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Small bank: defaults except CNT_W=3 so saturation is reachable.
  logic [1:0] a_en = '0, a_rev = '0, a_gate, a_upd;
  logic       a_clr = 1'b0;
  logic [4:0] a_d = '0;
  logic [9:0] a_out;
  logic [5:0] a_cnt;

  gated_reg_bank #(.WIDTH(5), .CHANNELS(2), .IDLE_CYCLES(4), .CNT_W(3)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(a_en), .REV(a_rev), .CLR(a_clr), .D_IN(a_d),
    .OUT(a_out), .GATE_OFF(a_gate), .UPD(a_upd), .LOAD_CNT(a_cnt)
  );

  // Wide bank for the random run.
  logic [3:0]  b_en = '0, b_rev = '0, b_gate, b_upd;
  logic        b_clr = 1'b0;
  logic [7:0]  b_d = '0;
  logic [31:0] b_out;
  logic [15:0] b_cnt;

  gated_reg_bank #(.WIDTH(8), .CHANNELS(4), .IDLE_CYCLES(3), .CNT_W(4)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(b_en), .REV(b_rev), .CLR(b_clr), .D_IN(b_d),
    .OUT(b_out), .GATE_OFF(b_gate), .UPD(b_upd), .LOAD_CNT(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reference state for the wide bank.
  logic [7:0] m_out [4];
  logic [3:0] m_cnt [4];
  int         m_idle [4];
  logic [3:0] m_upd;

  initial begin
    // Reset held across edges.
    tick();
    tick();
    check("rst_out", a_out, 10'd0);
    check("rst_gate", a_gate, 2'b00);
    check("rst_upd", a_upd, 2'b00);
    check("rst_cnt", a_cnt, 6'd0);
    check("rst_b_all", {b_out, b_gate, b_upd, b_cnt}, '0);
    rst_n = 1'b1;

    // Straight and reversed capture.
    a_rev = 2'b10; a_d = 5'b00011; a_en = 2'b11;
    tick();
    check("load_out", a_out, {5'b11000, 5'b00011});
    check("load_upd", a_upd, 2'b11);
    check("load_cnt", a_cnt, {3'd1, 3'd1});
    check("load_gate", a_gate, 2'b00);

    // Redundant reload.
    tick();
    check("redund_out", a_out, {5'b11000, 5'b00011});
    check("redund_upd", a_upd, 2'b00);
    check("redund_cnt", a_cnt, {3'd1, 3'd1});

    // Only ch0 enabled.
    a_d = 5'b00111; a_en = 2'b01;
    tick();
    check("ch0_out", a_out, {5'b11000, 5'b00111});
    check("ch0_upd", a_upd, 2'b01);
    check("ch0_cnt", a_cnt, {3'd1, 3'd2});

    // Idle run: ch1 was already idle for one edge, ch0 starts now.
    a_en = 2'b00;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("idle_gate0", a_gate[0], (e >= 4) ? 1'b1 : 1'b0);
      check("idle_gate1", a_gate[1], (e >= 3) ? 1'b1 : 1'b0);
      check("idle_upd", a_upd, 2'b00);
    end

    // Load while gated: performed normally and clears the request.
    a_en = 2'b01; a_d = 5'b01010;
    tick();
    check("wake_gate", a_gate, 2'b10);
    check("wake_out", a_out, {5'b11000, 5'b01010});
    check("wake_upd", a_upd, 2'b01);
    check("wake_cnt", a_cnt, {3'd1, 3'd3});

    // Counter saturation at 7.
    for (int e = 0; e < 9; e++) begin
      a_d = (e % 2 == 0) ? 5'b00001 : 5'b00010;
      tick();
    end
    check("sat_cnt", a_cnt, {3'd1, 3'd7});
    check("sat_upd", a_upd, 2'b01);
    check("sat_out", a_out, {5'b11000, 5'b00001});

    // CLR with a changing load: counters cleared, data and UPD unaffected.
    a_clr = 1'b1; a_d = 5'b00100;
    tick();
    check("clr_cnt", a_cnt, 6'd0);
    check("clr_out", a_out, {5'b11000, 5'b00100});
    check("clr_upd", a_upd, 2'b01);
    check("clr_gate", a_gate, 2'b00);
    a_clr = 1'b0;

    // Drive both channels to gated, then reset asynchronously mid-cycle.
    a_en = 2'b00;
    repeat (4) tick();
    check("pre_rst_gate", a_gate, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_out", a_out, 10'd0);
    check("async_gate", a_gate, 2'b00);
    check("async_cnt", a_cnt, 6'd0);
    tick();
    rst_n = 1'b1;
    a_en = 2'b01; a_rev = 2'b01; a_d = 5'b10000;
    tick();
    check("post_rst_out", a_out, {5'b00000, 5'b00001});
    check("post_rst_upd", a_upd, 2'b01);
    check("post_rst_cnt", a_cnt, {3'd0, 3'd1});

    // Random scoreboard on the wide bank, starting from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_out[c] = '0; m_cnt[c] = '0; m_idle[c] = 0;
    end
    m_upd = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic [31:0] exp_out;
      logic [15:0] exp_cnt;
      logic [3:0]  exp_gate;
      for (int c = 0; c < 4; c++) b_en[c] = ($urandom_range(0, 2) == 0);
      b_rev = 4'($urandom);
      b_clr = ($urandom_range(0, 40) == 0);
      b_d   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      for (int c = 0; c < 4; c++) begin
        logic [7:0] nv;
        logic       chg;
        nv  = b_rev[c] ? rev8(b_d) : b_d;
        chg = b_en[c] && (nv != m_out[c]);
        m_upd[c] = chg;
        if (b_en[c]) m_out[c] = nv;
        if (b_clr) m_cnt[c] = '0;
        else if (chg && m_cnt[c] != 4'hf) m_cnt[c] = m_cnt[c] + 4'd1;
        if (b_clr || b_en[c]) m_idle[c] = 0;
        else if (m_idle[c] < 3) m_idle[c] = m_idle[c] + 1;
      end
      tick();
      for (int c = 0; c < 4; c++) begin
        exp_out[c*8 +: 8]  = m_out[c];
        exp_cnt[c*4 +: 4]  = m_cnt[c];
        exp_gate[c]        = (m_idle[c] == 3);
      end
      check("rnd_out", b_out, exp_out);
      check("rnd_upd", b_upd, m_upd);
      check("rnd_cnt", b_cnt, exp_cnt);
      check("rnd_gate", b_gate, exp_gate);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
